bcast_tile_ctrl: RTL

BCAST_TILE_CTRL -- requirements
Module: bcast_tile_ctrl

---
 rtl/bcast_tile_ctrl_pkg.sv | 9 +
 rtl/bcast_tile_ctrl_gen.sv | 20 ++
 rtl/bcast_tile_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/bcast_tile_ctrl_pkg.sv
// bcast_tile_ctrl_pkg: shared FSM state encoding and broadcast mode constants
//   state_t   : controller states IDLE, READ, WAIT, ISSUE, DONE
//   BCAST_COL : tile[i][j] = vec[j] (every row is the vector)
//   BCAST_ROW : tile[i][j] = vec[i] (every column is the vector)
package bcast_tile_ctrl_pkg;
    typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_ISSUE, S_DONE} state_t;
    localparam logic BCAST_COL = 1'b0;
    localparam logic BCAST_ROW = 1'b1;
endpackage

// File: rtl/bcast_tile_ctrl_gen.sv
// broadcast_tile_gen: combinational vector-to-tile broadcast
//   mode    : BCAST_COL copies the vector into every row, BCAST_ROW into every column
//   vec_in  : TILE_SIZE signed elements
//   mat_out : TILE_SIZE x TILE_SIZE signed tile, mat_out[i][j]
module broadcast_tile_gen
    import bcast_tile_ctrl_pkg::*;
#(
    parameter int TILE_SIZE  = 4,
    parameter int DATA_WIDTH = 16
)(
    input  logic                                                  mode,
    input  logic signed [TILE_SIZE-1:0][DATA_WIDTH-1:0]           vec_in,
    output logic signed [TILE_SIZE-1:0][TILE_SIZE-1:0][DATA_WIDTH-1:0] mat_out
);
    for (genvar i = 0; i < TILE_SIZE; i++) begin : g_row
        for (genvar j = 0; j < TILE_SIZE; j++) begin : g_col
            assign mat_out[i][j] = (mode == BCAST_ROW) ? vec_in[i] : vec_in[j];
        end
    end
endmodule

// File: rtl/bcast_tile_ctrl.sv
// bcast_tile_ctrl: reads cmd_num vectors from memory and presents each as a broadcast tile
//   cmd_*      : command handshake (base address, tile count, broadcast mode)
//   rd_*       : vector-memory read port, rd_data valid one cycle after rd_en
//   tile_*     : tile handshake towards the array, tile_out held while stalled
//   busy, done : status; done pulses once when a command completes
module bcast_tile_ctrl
    import bcast_tile_ctrl_pkg::*;
#(
    parameter int TILE_SIZE  = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int CNT_WIDTH  = 8
)(
    input  logic                                                  clk,
    input  logic                                                  rst_n,
    input  logic                                                  cmd_valid,
    output logic                                                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0]                                 cmd_base,
    input  logic [CNT_WIDTH-1:0]                                  cmd_num,
    input  logic                                                  cmd_mode,
    output logic                                                  rd_en,
    output logic [ADDR_WIDTH-1:0]                                 rd_addr,
    input  logic signed [TILE_SIZE-1:0][DATA_WIDTH-1:0]           rd_data,
    output logic                                                  tile_valid,
    input  logic                                                  tile_ready,
    output logic signed [TILE_SIZE-1:0][TILE_SIZE-1:0][DATA_WIDTH-1:0] tile_out,
    output logic                                                  busy,
    output logic                                                  done
);
    state_t                                                  state;
    logic [ADDR_WIDTH-1:0]                                   addr;
    logic [CNT_WIDTH-1:0]                                    cnt;
    logic                                                    mode;
    logic                                                    last;
    logic                                                    accept;
    logic signed [TILE_SIZE-1:0][DATA_WIDTH-1:0]             vec;
    logic signed [TILE_SIZE-1:0][TILE_SIZE-1:0][DATA_WIDTH-1:0] mat;

    broadcast_tile_gen #(
        .TILE_SIZE (TILE_SIZE),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_gen (
        .mode   (mode),
        .vec_in (vec),
        .mat_out(mat)
    );

    assign accept   = cmd_valid && cmd_ready;
    assign last     = cnt == CNT_WIDTH'(1);
    assign rd_addr  = rd_en ? addr : '0;
    assign tile_out = tile_valid ? mat : '0;

    // Outputs are registered alongside the state so each one is a clean flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            addr       <= '0;
            cnt        <= '0;
            mode       <= BCAST_COL;
            vec        <= '0;
            cmd_ready  <= 1'b0;
            rd_en      <= 1'b0;
            tile_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // cmd_ready stays low through reset and rises on the first edge in IDLE
                    cmd_ready <= !accept;
                    if (accept) begin
                        addr  <= cmd_base;
                        cnt   <= cmd_num;
                        mode  <= cmd_mode;
                        busy  <= 1'b1;
                        state <= (cmd_num == '0) ? S_DONE : S_READ;
                        rd_en <= cmd_num != '0;
                        done  <= cmd_num == '0;
                    end
                end
                S_READ: begin
                    rd_en <= 1'b0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    vec        <= rd_data;
                    tile_valid <= 1'b1;
                    state      <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (tile_ready) begin
                        tile_valid <= 1'b0;
                        addr       <= addr + ADDR_WIDTH'(1);
                        cnt        <= cnt - CNT_WIDTH'(1);
                        state      <= last ? S_DONE : S_READ;
                        rd_en      <= !last;
                        done       <= last;
                    end
                end
                S_DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    state      <= S_IDLE;
                    rd_en      <= 1'b0;
                    tile_valid <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    cmd_ready  <= 1'b0;
                end
            endcase
        end
    end
endmodule
